// File: rtl/hap_pkg.sv
// Shared definitions for the processor control path: opcodes, sequencer
// state encoding and the compare-opcode classifier.
package hap_pkg;

  localparam int OPC_W = 5;

  // Compare opcodes, which load the condition flag.
  localparam logic [OPC_W-1:0] OP_LT   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_GT   = 5'b01100;
  localparam logic [OPC_W-1:0] OP_EQ   = 5'b01101;
  localparam logic [OPC_W-1:0] OP_GTE  = 5'b01110;
  localparam logic [OPC_W-1:0] OP_LTE  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_NE   = 5'b10000;

  // Control-flow opcodes.
  localparam logic [OPC_W-1:0] OP_JMP  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_BRT  = 5'b10010;
  localparam logic [OPC_W-1:0] OP_BRF  = 5'b10011;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_e;

  // Compare opcodes occupy one contiguous range, LT through NE.
  function automatic logic is_cmp(input logic [OPC_W-1:0] opcode);
    return (opcode >= OP_LT) && (opcode <= OP_NE);
  endfunction

endpackage

// File: rtl/branch_decide.sv
// Pure opcode/flag decode. Outputs are raw; the sequencer qualifies them
// with its RUN state and the step enable.
module branch_decide
  import hap_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag,
  output logic             take_branch,
  output logic             is_halt,
  output logic             update_flag
);

  // Branch resolution against the registered flag, HALT and compare detection.
  always_comb begin
    take_branch = 1'b0;
    is_halt     = 1'b0;
    update_flag = is_cmp(opcode);
    case (opcode)
      OP_JMP:  take_branch = 1'b1;
      OP_BRT:  take_branch = flag;
      OP_BRF:  take_branch = ~flag;
      OP_HALT: is_halt     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program counter owner and branch resolver. Drives the synchronous-read
// instruction memory, squashes the single wrong-path slot after a taken
// branch and parks in HALT until reset.
module branch_sequencer
  import hap_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic [PC_W-1:0]  instr_target,
  input  logic [2:0]       cmp_rd,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_en,
  output logic             issue_valid,
  output logic [PC_W-1:0]  ex_pc,
  output logic             flag,
  output logic             taken,
  output logic             halted
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ex_pc_q, ex_pc_d;
  logic            flag_q, flag_d;
  logic            halted_q, halted_d;

  logic dec_take;
  logic dec_halt;
  logic dec_upd;
  logic run_step;

  // Only bit 0 of the compare result carries the condition.
  logic unused_cmp_hi;
  assign unused_cmp_hi = ^cmp_rd[2:1];

  branch_decide u_decide (
    .opcode      (instr_opcode),
    .flag        (flag_q),
    .take_branch (dec_take),
    .is_halt     (dec_halt),
    .update_flag (dec_upd)
  );

  assign run_step = en && (state_q == ST_RUN);

  // Next-state logic; en=0 leaves every register at its current value.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ex_pc_d  = ex_pc_q;
    flag_d   = flag_q;
    halted_d = halted_q;
    if (en) begin
      case (state_q)
        ST_PRIME: begin
          pc_d    = PC_ONE;
          ex_pc_d = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (dec_halt) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            pc_d    = pc_q + PC_ONE;
            ex_pc_d = pc_q;
            if (dec_upd) flag_d = cmp_rd[0];
            if (dec_take) begin
              pc_d    = instr_target;
              state_d = ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // Wrong-path slot: advance only, ignore its opcode entirely.
          pc_d    = pc_q + PC_ONE;
          ex_pc_d = pc_q;
          state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous reset that overrides the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_PRIME;
      pc_q     <= '0;
      ex_pc_q  <= '0;
      flag_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ex_pc_q  <= ex_pc_d;
      flag_q   <= flag_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_en     = en;
  assign issue_valid = (state_q == ST_RUN);
  assign ex_pc       = ex_pc_q;
  assign flag        = flag_q;
  assign taken       = run_step && dec_take && !dec_halt;
  assign halted      = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Cycle-by-cycle table-driven bench for branch_sequencer with a small
// synchronous-read instruction memory model.
module tb_branch_sequencer;

  localparam int PC_W = 8;

  // Opcodes written out independently of the design package.
  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] LT   = 5'b01011;
  localparam logic [4:0] GT   = 5'b01100;
  localparam logic [4:0] EQ   = 5'b01101;
  localparam logic [4:0] JMP  = 5'b10001;
  localparam logic [4:0] BRT  = 5'b10010;
  localparam logic [4:0] BRF  = 5'b10011;
  localparam logic [4:0] HALT = 5'b11111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, en;
  logic [4:0]      instr_opcode = '0;
  logic [PC_W-1:0] instr_target = '0;
  logic            bus_cmp = 1'b0;
  logic [2:0]      cmp_rd;
  logic [PC_W-1:0] imem_addr, ex_pc;
  logic            imem_en, issue_valid, flag, taken, halted;

  // Upper cmp_rd bits are set to confirm only bit 0 matters.
  assign cmp_rd = {2'b10, bus_cmp};

  branch_sequencer #(.PC_W(PC_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .instr_opcode (instr_opcode),
    .instr_target (instr_target),
    .cmp_rd       (cmp_rd),
    .imem_addr    (imem_addr),
    .imem_en      (imem_en),
    .issue_valid  (issue_valid),
    .ex_pc        (ex_pc),
    .flag         (flag),
    .taken        (taken),
    .halted       (halted)
  );

  logic [4:0]      mem_op  [256];
  logic [PC_W-1:0] mem_tgt [256];
  logic            mem_cmp [256];

  always @(posedge clk) begin
    if (imem_en) begin
      instr_opcode <= mem_op[imem_addr];
      instr_target <= mem_tgt[imem_addr];
      bus_cmp      <= mem_cmp[imem_addr];
    end
  end

  typedef struct {
    bit rst;
    bit en;
    bit chk;
    bit iv;
    int ex;   // -1: not compared
    int pc;
    bit fl;
    bit tk;
    bit h;
  } row_t;

  row_t rows[$];
  int checks = 0;
  int errors = 0;

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_op[i] = NOP; mem_tgt[i] = '0; mem_cmp[i] = 1'b0;
    end
  endtask

  task automatic put(input int a, input logic [4:0] op, input int tgt, input bit c);
    mem_op[a] = op; mem_tgt[a] = PC_W'(tgt); mem_cmp[a] = c;
  endtask

  task automatic add(input bit r, input bit e, input bit c, input bit iv, input int ex,
                     input int pc, input bit fl, input bit tk, input bit h);
    row_t x;
    x.rst = r; x.en = e; x.chk = c; x.iv = iv; x.ex = ex; x.pc = pc;
    x.fl = fl; x.tk = tk; x.h = h;
    rows.push_back(x);
  endtask

  task automatic chk(input string tag, input int idx, input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s row %0d %s: got 0x%0h expected 0x%0h", tag, idx, name, act, exp);
    end
  endtask

  // Apply each row for one cycle, checking the pre-edge outputs.
  task automatic run_rows(input string tag);
    foreach (rows[i]) begin
      rst = rows[i].rst;
      en  = rows[i].en;
      #2;
      if (rows[i].chk) begin
        chk(tag, i, "issue_valid", int'(issue_valid), int'(rows[i].iv));
        if (rows[i].ex >= 0) chk(tag, i, "ex_pc", int'(ex_pc), rows[i].ex);
        chk(tag, i, "imem_addr", int'(imem_addr), rows[i].pc);
        chk(tag, i, "imem_en", int'(imem_en), int'(rows[i].en));
        chk(tag, i, "flag", int'(flag), int'(rows[i].fl));
        chk(tag, i, "taken", int'(taken), int'(rows[i].tk));
        chk(tag, i, "halted", int'(halted), int'(rows[i].h));
      end
      @(posedge clk);
      #1;
    end
    $display("sequence %s: %0d cycles applied, errors so far %0d", tag, rows.size(), errors);
    rows.delete();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    @(posedge clk);
    #1;

    // A: straight line, EQ sets flag, BRT taken, wrong-path HALT squashed.
    clear_mem();
    put(2, EQ, 0, 1'b1);
    put(3, BRT, 'h40, 1'b0);
    put(4, HALT, 0, 1'b0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 0, 0);
    add(0, 1, 1, 1, 1, 'h02, 0, 0, 0);
    add(0, 1, 1, 1, 2, 'h03, 0, 0, 0);
    add(0, 1, 1, 1, 3, 'h04, 1, 1, 0);
    add(0, 1, 1, 0, 4, 'h40, 1, 0, 0);
    add(0, 1, 1, 1, 'h40, 'h41, 1, 0, 0);
    add(0, 1, 1, 1, 'h41, 'h42, 1, 0, 0);
    run_rows("eq_brt");

    // B: LT clears flag, BRT falls through, BRF taken, JMP squashes HALT.
    clear_mem();
    put(2, LT, 0, 1'b0);
    put(3, BRT, 'h40, 1'b0);
    put(4, BRF, 'h10, 1'b0);
    put(5, GT, 0, 1'b1);
    put('h11, JMP, 'h20, 1'b0);
    put('h12, HALT, 0, 1'b0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 0, 0);
    add(0, 1, 1, 1, 1, 'h02, 0, 0, 0);
    add(0, 1, 1, 1, 2, 'h03, 0, 0, 0);
    add(0, 1, 1, 1, 3, 'h04, 0, 0, 0);
    add(0, 1, 1, 1, 4, 'h05, 0, 1, 0);
    add(0, 1, 1, 0, 5, 'h10, 0, 0, 0);
    add(0, 1, 1, 1, 'h10, 'h11, 0, 0, 0);
    add(0, 1, 1, 1, 'h11, 'h12, 0, 1, 0);
    add(0, 1, 1, 0, 'h12, 'h20, 0, 0, 0);
    add(0, 1, 1, 1, 'h20, 'h21, 0, 0, 0);
    add(0, 1, 1, 1, 'h21, 'h22, 0, 0, 0);
    run_rows("brt_brf_jmp");

    // C: stall on a branch and through FLUSH, then reset during FLUSH.
    clear_mem();
    put(2, EQ, 0, 1'b1);
    put(3, BRT, 'h40, 1'b0);
    put(4, HALT, 0, 1'b0);
    put('h41, JMP, 'h60, 1'b0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 0, 0);
    add(0, 1, 1, 1, 1, 'h02, 0, 0, 0);
    add(0, 1, 1, 1, 2, 'h03, 0, 0, 0);
    add(0, 0, 1, 1, 3, 'h04, 1, 0, 0);
    add(0, 1, 1, 1, 3, 'h04, 1, 1, 0);
    add(0, 0, 1, 0, 4, 'h40, 1, 0, 0);
    add(0, 0, 1, 0, 4, 'h40, 1, 0, 0);
    add(0, 0, 1, 0, 4, 'h40, 1, 0, 0);
    add(0, 1, 1, 0, 4, 'h40, 1, 0, 0);
    add(0, 1, 1, 1, 'h40, 'h41, 1, 0, 0);
    add(0, 1, 1, 1, 'h41, 'h42, 1, 1, 0);
    add(1, 0, 1, 0, 'h42, 'h60, 1, 0, 0);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 0, 0);
    run_rows("stall_flush");

    // D: BRF into 0xFE, wrap 0xFF->0x00, fall through, HALT, reset out.
    clear_mem();
    put(0, BRF, 'hFE, 1'b0);
    put('hFE, EQ, 0, 1'b1);
    put(1, HALT, 0, 1'b0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 1, 0);
    add(0, 1, 1, 0, 1, 'hFE, 0, 0, 0);
    add(0, 1, 1, 1, 'hFE, 'hFF, 0, 0, 0);
    add(0, 1, 1, 1, 'hFF, 'h00, 1, 0, 0);
    add(0, 1, 1, 1, 'h00, 'h01, 1, 0, 0);
    add(0, 1, 1, 1, 'h01, 'h02, 1, 0, 0);
    add(0, 1, 1, 0, -1, 'h02, 1, 0, 1);
    add(0, 1, 1, 0, -1, 'h02, 1, 0, 1);
    add(1, 0, 1, 0, -1, 'h02, 1, 0, 1);
    add(0, 1, 1, 0, 0, 'h00, 0, 0, 0);
    add(0, 1, 1, 1, 0, 'h01, 0, 1, 0);
    run_rows("wrap_halt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
